// File: rtl/ram_burst_controller_if.sv
// ram_burst_controller_if: CPU word port plus narrow RAM bus of the burst controller.
// The slave modport is the controller's view; the master modport is the CPU/RAM side.
interface ram_burst_controller_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RAM_W  = 8,
    parameter int unsigned BANK_W = 2,
    parameter int unsigned BG_W   = 2,
    parameter int unsigned ROW_W  = 18,
    parameter int unsigned COL_W  = 10
);
    localparam int unsigned ADDR_W = BANK_W + BG_W + ROW_W + COL_W + $clog2(DATA_W / 8);

    // CPU side
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] datain;
    logic              read;
    logic              write;
    logic              ready;
    logic [DATA_W-1:0] dataout;
    logic              done;
    // RAM side
    logic [RAM_W-1:0]  ramdatain;
    logic [RAM_W-1:0]  ramdataout;
    logic              ramdata_oe;
    logic [BANK_W-1:0] bank;
    logic [BG_W-1:0]   bankgroup;
    logic [ROW_W-1:0]  addressram;
    logic              cs_n;
    logic              act_n;
    logic              rd;
    logic              wr;
    logic              pre;
    logic              refresh;
    logic              ramreset;

    modport slave (
        input  address, datain, read, write, ramdatain,
        output ready, dataout, done, ramdataout, ramdata_oe, bank, bankgroup, addressram,
               cs_n, act_n, rd, wr, pre, refresh, ramreset
    );

    modport master (
        output address, datain, read, write, ramdatain,
        input  ready, dataout, done, ramdataout, ramdata_oe, bank, bankgroup, addressram,
               cs_n, act_n, rd, wr, pre, refresh, ramreset
    );
endinterface

// File: rtl/ram_burst_controller.sv
// ram_burst_controller: bridges one CPU word port to a narrow DDR-style RAM bus.
// Each access becomes ACT / RD|WR / beat burst / PRE, words are serialised into RAM_W-bit
// beats (beat 0 = LSBs) and refresh is inserted between transfers.
// Optional feature macro OPEN_PAGE_EN: rows stay open after a transfer, tracked per
// bank/bank-group; hits skip ACT, misses precharge first, refresh closes all rows first.
// Assumes DATA_W is a multiple of RAM_W with at least two beats per word.
module ram_burst_controller #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned RAM_W    = 8,
    parameter int unsigned BANK_W   = 2,
    parameter int unsigned BG_W     = 2,
    parameter int unsigned ROW_W    = 18,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned TRCD     = 2,
    parameter int unsigned TCL      = 3,
    parameter int unsigned TRP      = 2,
    parameter int unsigned TRFC     = 8,
    parameter int unsigned REF_INT  = 1024,
    parameter int unsigned INIT_CYC = 16
) (
    input logic                   clock,
    input logic                   resetin,
    ram_burst_controller_if.slave bus
);
    localparam int unsigned BYTE_W  = $clog2(DATA_W / 8);
    localparam int unsigned BEATS   = DATA_W / RAM_W;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned REF_W   = $clog2(REF_INT);
    localparam int unsigned COL_LO  = BYTE_W;
    localparam int unsigned ROW_LO  = COL_LO + COL_W;
    localparam int unsigned BG_LO   = ROW_LO + ROW_W;
    localparam int unsigned BANK_LO = BG_LO + BG_W;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_INT - 1);

    typedef enum logic [3:0] {
        StInit, StIdle, StAct, StTrcdW, StCmd, StCasW, StBurst, StDone,
        StPre, StTrpW, StRef, StTrfcW
    } state_e;

    state_e state_q, state_d, after_pre, done_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_cnt_q;
    logic              ref_pend_q;
    logic              op_rd_q;
    logic [BANK_W-1:0] bank_q;
    logic [BG_W-1:0]   bg_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [DATA_W-1:0] wshift_q, rbuf_q, rbuf_d, dataout_q;

    logic              ready, accept, open_any, req_hit, req_conflict;
    logic [BANK_W-1:0] req_bank;
    logic [BG_W-1:0]   req_bg;
    logic [ROW_W-1:0]  req_row;
    logic              unused_byte;

    logic              cs_n, act_n, rd, wr, pre, refresh, ramreset, ramdata_oe, done;
    logic [ROW_W-1:0]  addressram;
    logic [RAM_W-1:0]  ramdataout;

    assign req_bank    = bus.address[BANK_LO +: BANK_W];
    assign req_bg      = bus.address[BG_LO +: BG_W];
    assign req_row     = bus.address[ROW_LO +: ROW_W];
    assign unused_byte = ^bus.address[BYTE_W-1:0];

    assign ready  = (state_q == StIdle) && !ref_pend_q;
    assign accept = (bus.read || bus.write) && ready;
    // Read beats shift in from the top so beat 0 ends up in the LSBs.
    assign rbuf_d = {bus.ramdatain, rbuf_q[DATA_W-1:RAM_W]};

`ifdef OPEN_PAGE_EN
    localparam int unsigned NBANK = 1 << (BANK_W + BG_W);
    logic [NBANK-1:0]            open_q;
    logic [NBANK-1:0][ROW_W-1:0] open_row_q;
    logic [BANK_W+BG_W-1:0]      req_idx, cur_idx;
    logic                        op_act_q;

    assign req_idx      = {req_bank, req_bg};
    assign cur_idx      = {bank_q, bg_q};
    assign open_any     = |open_q;
    assign req_hit      = open_q[req_idx] && (open_row_q[req_idx] == req_row);
    assign req_conflict = open_q[req_idx] && (open_row_q[req_idx] != req_row);
    // A PRE with a transfer in flight is a row miss; otherwise it closes rows for refresh.
    assign after_pre    = op_act_q ? StAct : StRef;
    assign done_next    = StIdle;

    // Open-row table and in-flight flag.
    always_ff @(posedge clock or posedge resetin) begin
        if (resetin) begin
            open_q     <= '0;
            open_row_q <= '0;
            op_act_q   <= 1'b0;
        end else begin
            if (accept) op_act_q <= 1'b1;
            else if (state_q == StDone) op_act_q <= 1'b0;
            if (state_q == StAct) begin
                open_q[cur_idx]     <= 1'b1;
                open_row_q[cur_idx] <= row_q;
            end else if (state_q == StPre && !op_act_q) begin
                open_q <= '0;
            end
        end
    end
`else
    assign open_any     = 1'b0;
    assign req_hit      = 1'b0;
    assign req_conflict = 1'b0;
    assign after_pre    = StIdle;
    assign done_next    = StPre;
`endif

    // State and wait-counter register.
    always_ff @(posedge clock or posedge resetin) begin
        if (resetin) begin
            state_q <= StInit;
            cnt_q   <= CNT_W'(INIT_CYC - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait-counter reload; cnt_q counts down to zero in each wait state.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        case (state_q)
            StInit:  if (cnt_q == '0) state_d = StIdle;
            StIdle: begin
                if (ref_pend_q) begin
                    state_d = open_any ? StPre : StRef;
                end else if (accept) begin
                    state_d = req_hit ? StCmd : (req_conflict ? StPre : StAct);
                end
            end
            StAct: begin
                if (TRCD > 1) begin
                    state_d = StTrcdW;
                    cnt_d   = CNT_W'(TRCD - 2);
                end else begin
                    state_d = StCmd;
                end
            end
            StTrcdW: if (cnt_q == '0) state_d = StCmd;
            StCmd: begin
                if (op_rd_q && TCL > 1) begin
                    state_d = StCasW;
                    cnt_d   = CNT_W'(TCL - 2);
                end else begin
                    state_d = StBurst;
                    cnt_d   = CNT_W'(BEATS - 1);
                end
            end
            StCasW: begin
                if (cnt_q == '0) begin
                    state_d = StBurst;
                    cnt_d   = CNT_W'(BEATS - 1);
                end
            end
            StBurst: if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = done_next;
            StPre: begin
                if (TRP > 1) begin
                    state_d = StTrpW;
                    cnt_d   = CNT_W'(TRP - 2);
                end else begin
                    state_d = after_pre;
                end
            end
            StTrpW:  if (cnt_q == '0) state_d = after_pre;
            StRef: begin
                if (TRFC > 1) begin
                    state_d = StTrfcW;
                    cnt_d   = CNT_W'(TRFC - 2);
                end else begin
                    state_d = StIdle;
                end
            end
            StTrfcW: if (cnt_q == '0) state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Command pins and write beats decoded from the current state.
    always_comb begin
        cs_n       = 1'b1;
        act_n      = 1'b1;
        rd         = 1'b0;
        wr         = 1'b0;
        pre        = 1'b0;
        refresh    = 1'b0;
        ramreset   = 1'b0;
        ramdata_oe = 1'b0;
        done       = 1'b0;
        addressram = '0;
        ramdataout = '0;
        case (state_q)
            StInit: ramreset = 1'b1;
            StAct: begin
                cs_n       = 1'b0;
                act_n      = 1'b0;
                addressram = row_q;
            end
            StCmd: begin
                cs_n       = 1'b0;
                rd         = op_rd_q;
                wr         = !op_rd_q;
                addressram = ROW_W'(col_q);
            end
            StBurst: begin
                if (!op_rd_q) begin
                    ramdata_oe = 1'b1;
                    ramdataout = wshift_q[RAM_W-1:0];
                end
            end
            StDone: done = 1'b1;
            StPre: begin
                cs_n = 1'b0;
                pre  = 1'b1;
            end
            StRef: begin
                cs_n    = 1'b0;
                refresh = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and burst data shifting; dataout only updates when a read completes.
    always_ff @(posedge clock or posedge resetin) begin
        if (resetin) begin
            op_rd_q   <= 1'b0;
            bank_q    <= '0;
            bg_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wshift_q  <= '0;
            rbuf_q    <= '0;
            dataout_q <= '0;
        end else begin
            if (accept) begin
                op_rd_q  <= bus.read;
                bank_q   <= req_bank;
                bg_q     <= req_bg;
                row_q    <= req_row;
                col_q    <= bus.address[COL_LO +: COL_W];
                wshift_q <= bus.datain;
            end
            if (state_q == StBurst) begin
                if (op_rd_q) begin
                    rbuf_q <= rbuf_d;
                    if (cnt_q == '0) dataout_q <= rbuf_d;
                end else begin
                    wshift_q <= wshift_q >> RAM_W;
                end
            end
        end
    end

    // Refresh interval counter; an expiry while already pending leaves it set.
    always_ff @(posedge clock or posedge resetin) begin
        if (resetin) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
            if (state_q == StRef) ref_pend_q <= 1'b0;
        end
    end

    assign bus.ready      = ready;
    assign bus.dataout    = dataout_q;
    assign bus.done       = done;
    assign bus.ramdataout = ramdataout;
    assign bus.ramdata_oe = ramdata_oe;
    assign bus.bank       = bank_q;
    assign bus.bankgroup  = bg_q;
    assign bus.addressram = addressram;
    assign bus.cs_n       = cs_n;
    assign bus.act_n      = act_n;
    assign bus.rd         = rd;
    assign bus.wr         = wr;
    assign bus.pre        = pre;
    assign bus.refresh    = refresh;
    assign bus.ramreset   = ramreset;
endmodule

// File: tb/tb_ram_burst_controller.sv
// tb_ram_burst_controller: directed checks of the burst controller with default parameters.
module tb_ram_burst_controller;
    localparam int TCL   = 3;
    localparam int BEATS = 8;
    localparam logic [5:0] C_IDLE = 6'b110000;
    localparam logic [5:0] C_ACT  = 6'b000000;
    localparam logic [5:0] C_RD   = 6'b011000;
    localparam logic [5:0] C_WR   = 6'b010100;
    localparam logic [5:0] C_PRE  = 6'b010010;
    localparam logic [5:0] C_REF  = 6'b010001;
    // {bank, bankgroup, row, col, byte}
    localparam logic [34:0] ADDR_A  = {2'd1, 2'd2, 18'h00155, 10'h02A, 3'd0};
    localparam logic [34:0] ADDR_A5 = {2'd1, 2'd2, 18'h00155, 10'h02A, 3'd5};
    localparam logic [34:0] ADDR_B  = {2'd1, 2'd2, 18'h000AA, 10'h011, 3'd0};

    logic        clock   = 1'b0;
    logic        resetin = 1'b1;
    logic [63:0] rd_word = 64'h0;
    int          rd_age  = -1;
    int          n_cmp   = 0;
    int          n_fail  = 0;
    logic [5:0]  cmd;

    ram_burst_controller_if #(
        .DATA_W(64), .RAM_W(8), .BANK_W(2), .BG_W(2), .ROW_W(18), .COL_W(10)
    ) bus ();

    ram_burst_controller #(
        .DATA_W(64), .RAM_W(8), .BANK_W(2), .BG_W(2), .ROW_W(18), .COL_W(10),
        .TRCD(2), .TCL(3), .TRP(2), .TRFC(8), .REF_INT(1024), .INIT_CYC(16)
    ) dut (
        .clock  (clock),
        .resetin(resetin),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    assign cmd = {bus.cs_n, bus.act_n, bus.rd, bus.wr, bus.pre, bus.refresh};

    // RAM model: beat i of rd_word appears TCL+i cycles after a READ command.
    always @(negedge clock) begin
        if (bus.cs_n === 1'b0 && bus.rd === 1'b1) rd_age = 0;
        else if (rd_age >= 0) rd_age = rd_age + 1;
        if (rd_age >= TCL && rd_age < TCL + BEATS) bus.ramdatain = rd_word[(rd_age - TCL) * 8 +: 8];
        else bus.ramdatain = 8'h00;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        resetin = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (bus.ramreset !== 1'b1) begin n_fail++; $display("FAIL rst_ramreset got %b exp 1", bus.ramreset); end
        n_cmp++; if (cmd !== C_IDLE) begin n_fail++; $display("FAIL rst_cmd got %b exp %b", cmd, C_IDLE); end
        n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", bus.ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", bus.done); end
        n_cmp++; if (bus.dataout !== 64'h0) begin n_fail++; $display("FAIL rst_dataout got %h exp 0", bus.dataout); end
        n_cmp++; if ({bus.ramdata_oe, bus.ramdataout} !== 9'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", {bus.ramdata_oe, bus.ramdataout}); end
        n_cmp++; if ({bus.bank, bus.bankgroup, bus.addressram} !== 22'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", {bus.bank, bus.bankgroup, bus.addressram}); end
        resetin = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.ramreset !== (k < 16)) begin n_fail++; $display("FAIL init_ramreset k=%0d got %b exp %b", k, bus.ramreset, (k < 16)); end
            n_cmp++; if (bus.ready !== (k == 16)) begin n_fail++; $display("FAIL init_ready k=%0d got %b exp %b", k, bus.ready, (k == 16)); end
            n_cmp++; if (cmd !== C_IDLE) begin n_fail++; $display("FAIL init_cmd k=%0d got %b exp %b", k, cmd, C_IDLE); end
        end
    endtask

    task automatic test_write;
        bit ok;
        logic [5:0] exp_cmd;
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_ready_timeout got 0 exp 1"); end
        bus.address = ADDR_A;
        bus.datain  = 64'h0807060504030201;
        bus.write   = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clock);
            bus.write = 1'b0;
            exp_cmd = (t == 1) ? C_ACT : (t == 3) ? C_WR : (t == 13) ? C_PRE : C_IDLE;
            n_cmp++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL wr_cmd t=%0d got %b exp %b", t, cmd, exp_cmd); end
            n_cmp++; if (bus.ramdata_oe !== (t >= 4 && t <= 11)) begin n_fail++; $display("FAIL wr_oe t=%0d got %b exp %b", t, bus.ramdata_oe, (t >= 4 && t <= 11)); end
            if (t >= 4 && t <= 11) begin
                n_cmp++; if (bus.ramdataout !== 8'(t - 3)) begin n_fail++; $display("FAIL wr_beat t=%0d got %h exp %h", t, bus.ramdataout, 8'(t - 3)); end
            end
            n_cmp++; if (bus.done !== (t == 12)) begin n_fail++; $display("FAIL wr_done t=%0d got %b exp %b", t, bus.done, (t == 12)); end
            if (t == 1) begin
                n_cmp++; if ({bus.bank, bus.bankgroup, bus.addressram} !== {2'd1, 2'd2, 18'h00155}) begin n_fail++; $display("FAIL wr_act_addr got %h exp %h", {bus.bank, bus.bankgroup, bus.addressram}, {2'd1, 2'd2, 18'h00155}); end
            end
            if (t == 3) begin
                n_cmp++; if (bus.addressram !== 18'h0002A) begin n_fail++; $display("FAIL wr_col got %h exp 2a", bus.addressram); end
            end
        end
    endtask

    task automatic test_read;
        bit ok;
        logic [5:0] exp_cmd;
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_ready_timeout got 0 exp 1"); end
        rd_word     = 64'h0807060504030201;
        bus.address = ADDR_A5;
        bus.read    = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clock);
            bus.read = 1'b0;
            exp_cmd = (t == 1) ? C_ACT : (t == 3) ? C_RD : (t == 15) ? C_PRE : C_IDLE;
            n_cmp++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL rd_cmd t=%0d got %b exp %b", t, cmd, exp_cmd); end
            n_cmp++; if (bus.done !== (t == 14)) begin n_fail++; $display("FAIL rd_done t=%0d got %b exp %b", t, bus.done, (t == 14)); end
            n_cmp++; if (bus.ramdata_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe t=%0d got %b exp 0", t, bus.ramdata_oe); end
            if (t == 3) begin
                n_cmp++; if (bus.addressram !== 18'h0002A) begin n_fail++; $display("FAIL rd_col got %h exp 2a", bus.addressram); end
            end
            if (t == 14 || t == 16) begin
                n_cmp++; if (bus.dataout !== 64'h0807060504030201) begin n_fail++; $display("FAIL rd_data t=%0d got %h exp 0807060504030201", t, bus.dataout); end
            end
        end
    endtask

    task automatic test_read_write;
        bit ok;
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rw_ready_timeout got 0 exp 1"); end
        rd_word     = 64'hA1B2C3D4E5F60718;
        bus.address = ADDR_A;
        bus.datain  = 64'hFFEEDDCCBBAA9988;
        bus.read    = 1'b1;
        bus.write   = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clock);
            bus.read  = 1'b0;
            bus.write = 1'b0;
            if (t == 3) begin
                n_cmp++; if (cmd !== C_RD) begin n_fail++; $display("FAIL rw_cmd got %b exp %b", cmd, C_RD); end
            end
            n_cmp++; if (bus.ramdata_oe !== 1'b0) begin n_fail++; $display("FAIL rw_oe t=%0d got %b exp 0", t, bus.ramdata_oe); end
            if (t == 14) begin
                n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rw_done got %b exp 1", bus.done); end
                n_cmp++; if (bus.dataout !== 64'hA1B2C3D4E5F60718) begin n_fail++; $display("FAIL rw_data got %h exp a1b2c3d4e5f60718", bus.dataout); end
            end
        end
    endtask

    task automatic test_reset_midburst;
        bit ok;
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mb_ready_timeout got 0 exp 1"); end
        bus.address = ADDR_A;
        bus.read    = 1'b1;
        repeat (8) begin
            @(negedge clock);
            bus.read = 1'b0;
        end
        resetin = 1'b1;
        #1;
        n_cmp++; if (bus.ramreset !== 1'b1) begin n_fail++; $display("FAIL mb_ramreset got %b exp 1", bus.ramreset); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mb_done got %b exp 0", bus.done); end
        @(negedge clock);
        resetin = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mb_done k=%0d got %b exp 0", k, bus.done); end
            n_cmp++; if (bus.ramreset !== (k < 16)) begin n_fail++; $display("FAIL mb_ramreset k=%0d got %b exp %b", k, bus.ramreset, (k < 16)); end
            n_cmp++; if (bus.ready !== (k == 16)) begin n_fail++; $display("FAIL mb_ready k=%0d got %b exp %b", k, bus.ready, (k == 16)); end
        end
        n_cmp++; if (bus.dataout !== 64'h0) begin n_fail++; $display("FAIL mb_dataout got %h exp 0", bus.dataout); end
    endtask

    // Fresh reset, read held high: 17-cycle transfers accepted at k=16+17m; pending from
    // k=1024 so the transfer accepted at 1019 finishes, IDLE at 1036, REF at 1037.
    task automatic test_refresh;
        int refs  = 0;
        int dones = 0;
        resetin = 1'b1;
        @(negedge clock);
        resetin     = 1'b0;
        rd_word     = 64'h1111111111111111;
        bus.address = ADDR_A;
        bus.read    = 1'b1;
        for (int k = 1; k <= 1046; k++) begin
            @(negedge clock);
            if (cmd === C_REF) refs++;
            if (bus.done === 1'b1 && k < 1037) dones++;
            if (k == 1036) begin
                n_cmp++; if ({bus.ready, cmd} !== {1'b0, C_IDLE}) begin n_fail++; $display("FAIL ref_pending got %b exp %b", {bus.ready, cmd}, {1'b0, C_IDLE}); end
            end
            if (k == 1037) begin
                n_cmp++; if (cmd !== C_REF) begin n_fail++; $display("FAIL ref_cmd got %b exp %b", cmd, C_REF); end
            end
            if (k == 1044) begin
                n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL ref_trfc_ready got %b exp 0", bus.ready); end
            end
            if (k == 1045) begin
                n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL ref_end_ready got %b exp 1", bus.ready); end
            end
        end
        bus.read = 1'b0;
        n_cmp++; if (refs != 1) begin n_fail++; $display("FAIL ref_count got %0d exp 1", refs); end
        n_cmp++; if (dones != 60) begin n_fail++; $display("FAIL ref_dones got %0d exp 60", dones); end
    endtask

`ifdef OPEN_PAGE_EN
    task automatic test_open_page;
        bit ok;
        int seen = 0;
        resetin = 1'b1;
        @(negedge clock);
        resetin = 1'b0;
        wait_ready(ok);
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL op_ready_timeout got 0 exp 1"); end
        rd_word     = 64'h0807060504030201;
        bus.address = ADDR_A;
        bus.read    = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            @(negedge clock);
            bus.read = 1'b0;
            if (t == 1) begin
                n_cmp++; if (cmd !== C_ACT) begin n_fail++; $display("FAIL op_first_act got %b exp %b", cmd, C_ACT); end
            end
            if (cmd === C_PRE) seen++;
        end
        n_cmp++; if (seen != 0 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL op_no_pre got %0d/%b exp 0/1", seen, bus.ready); end
        bus.read = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clock);
            bus.read = 1'b0;
            n_cmp++; if (cmd !== ((t == 1) ? C_RD : C_IDLE)) begin n_fail++; $display("FAIL op_hit_cmd t=%0d got %b exp %b", t, cmd, (t == 1) ? C_RD : C_IDLE); end
            n_cmp++; if (bus.done !== (t == 12)) begin n_fail++; $display("FAIL op_hit_done t=%0d got %b exp %b", t, bus.done, (t == 12)); end
        end
        n_cmp++; if (bus.dataout !== 64'h0807060504030201) begin n_fail++; $display("FAIL op_hit_data got %h exp 0807060504030201", bus.dataout); end
        @(negedge clock);
        bus.address = ADDR_B;
        bus.read    = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clock);
            bus.read = 1'b0;
            if (t == 1) begin
                n_cmp++; if (cmd !== C_PRE) begin n_fail++; $display("FAIL op_miss_pre got %b exp %b", cmd, C_PRE); end
            end
            if (t == 3) begin
                n_cmp++; if ({cmd, bus.addressram} !== {C_ACT, 18'h000AA}) begin n_fail++; $display("FAIL op_miss_act got %h exp %h", {cmd, bus.addressram}, {C_ACT, 18'h000AA}); end
            end
            if (t == 5) begin
                n_cmp++; if (cmd !== C_RD) begin n_fail++; $display("FAIL op_miss_rd got %b exp %b", cmd, C_RD); end
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        bus.address   = '0;
        bus.datain    = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.ramdatain = '0;
        test_reset();
`ifndef OPEN_PAGE_EN
        test_write();
        test_read();
        test_read_write();
`endif
        test_reset_midburst();
`ifndef OPEN_PAGE_EN
        test_refresh();
`else
        test_open_page();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
